ps2_arrow_decoder: RTL and testbench
====================================

Name: ps2_arrow_decoder

Overview:
- Receives PS/2 keyboard frames and decodes the four arrow keys and Enter.
- Drives the one-hot `keys[3:0]` vector and the `select` level consumed by the cursor/level navigation block.
- Sits between the board's PS/2 pins and the game-control logic in the VGA project, in the single system clock domain.

Parameters:
TIMEOUT_CYCLES, 50000, clocks without a PS/2 falling edge before an in-progress frame is aborted (1 ms at 50 MHz)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock pin (asynchronous)
ps2_data  input  1  raw PS/2 data pin (asynchronous)
keys  output  4  one-hot held arrow key: bit0 up, bit1 down, bit2 left, bit3 right; 0 = none
select  output  1  high while Enter is held
scan_code  output  8  last correctly received byte
code_valid  output  1  one-cycle pulse, scan_code updated
frame_err  output  1  one-cycle pulse on parity, stop-bit or timeout error

Behaviour:
- Interface: one clock (`clock`); reset (`reset`) is asynchronous and active-high.
- Reset: `keys`=0, `select`=0, `scan_code`=0, `code_valid`=0, `frame_err`=0, FSM=IDLE, bit count=0, ext/brk flags=0, timeout counter=0. Reset mid-frame discards the partial byte.
- Input sync: `ps2_clk` and `ps2_data` each pass through 2 flip-flops. A falling edge is sync_clk previous=1, current=0. Data is sampled on the same cycle the edge is detected.
- Frame FSM:
  - IDLE: on a falling edge with data=0, go to DATA and set bit count=0. Data=1 is ignored as a glitch.
  - DATA: on each falling edge, shift data in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: on a falling edge, latch the parity bit and go to STOP.
  - STOP: on a falling edge, return to IDLE.
    - If stop=1 and XOR of the 8 data bits with the parity bit = 1 (odd parity): `scan_code`<=byte and `code_valid` pulses for 1 cycle.
    - Otherwise: `frame_err` pulses for 1 cycle and `scan_code` is unchanged.
- Latency: `code_valid` is high in the cycle after the synchronized stop-bit falling edge is detected, about 3 clocks after the pin edge.
- Timeout: the counter clears on every falling edge and in IDLE; it increments each clock in DATA, PARITY and STOP. When it reaches TIMEOUT_CYCLES-1: FSM returns to IDLE, `frame_err` pulses, ext/brk flags clear, and `keys`/`select` are unchanged.
- Decoder, acting on each `code_valid`:
  - 0xE0: set ext.
  - 0xF0: set brk.
  - Any other byte: act on it, then clear both ext and brk.
  - ext=1 arrow codes: 0x75 up, 0x72 down, 0x6B left, 0x74 right.
    - Make (brk=0): `keys`<=one-hot of that key. The last-pressed key wins, replacing any other bit.
    - Break (brk=1): `keys`<=0 only if `keys` equals that key's one-hot; otherwise unchanged.
  - ext=0, code 0x5A (Enter): `select`<=!brk.
  - Any other code is ignored, flags still clear.
  - Typematic repeat makes re-write the same value, so no output glitch occurs.
- `keys`/`select` update in the cycle `code_valid` is high, as a registered output visible the next cycle. `keys` is never multi-hot.
- A `frame_err` clears ext/brk so that a corrupted prefix cannot alter a later code.
- Simultaneous events: the timeout and a falling edge in the same cycle resolve as the edge (counter clears, frame continues).

Test Plan:
- Reset asserted mid-frame (after 4 data bits) then released, followed by a full frame 0x5A → no `code_valid` from the partial frame; then `code_valid` with `scan_code`=0x5A and `select`=1.
- Frames E0,75 then E0,F0,75 → `keys`=4'b0001 after the 2nd `code_valid`, `keys`=4'b0000 after the 5th; 5 `code_valid` pulses, no `frame_err`.
- Frames E0,6B then E0,74 then E0,F0,6B → `keys`=0100, then 1000, then remains 1000 (release of a non-current key is ignored).
- Frame 0x72 with the parity bit flipped, after a good E0 → `frame_err` pulses once, `scan_code` stays 0xE0, ext flag cleared; a following good 0x72 (no E0) leaves `keys`=0000.
- Start bit and 3 data bits, then ps2_clk held high for TIMEOUT_CYCLES (set to 100 in the bench) → `frame_err` on cycle 99 after the last edge, FSM back in IDLE; next full frame E0 decodes normally.
- Frames F0,5A while `select`=1, with a 0x1C ('A') inserted beforehand → 0x1C causes no output change; after F0,5A `select`=0, `keys` unchanged.

Source files
------------

// File: rtl/ps2_arrow_decoder.sv
// PS/2 keyboard frame receiver with arrow-key / Enter decoder.
// Drives a one-hot held-arrow vector and an Enter-held level for the game controls.
module ps2_arrow_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] keys,
    output logic       select,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clkSync_q, dataSync_q;
    logic          clkPrev_q;
    state_t        state_q, state_d;
    logic [2:0]    bitCnt_q, bitCnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [CW-1:0] toCnt_q, toCnt_d;
    logic [7:0]    scanCode_q, scanCode_d;
    logic          codeValid_q, codeValid_d;
    logic          frameErr_q, frameErr_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [3:0]    keys_q, keys_d;
    logic          select_q, select_d;
    logic          fall, dataBit;
    logic [3:0]    arrowOh;

    // Sync flops reset to the idle-high line level so reset never fakes an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
            clkPrev_q  <= 1'b1;
        end else begin
            clkSync_q  <= {clkSync_q[0], ps2_clk};
            dataSync_q <= {dataSync_q[0], ps2_data};
            clkPrev_q  <= clkSync_q[1];
        end
    end

    assign fall    = clkPrev_q & ~clkSync_q[1];
    assign dataBit = dataSync_q[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            toCnt_q     <= '0;
            scanCode_q  <= '0;
            codeValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            keys_q      <= '0;
            select_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            toCnt_q     <= toCnt_d;
            scanCode_q  <= scanCode_d;
            codeValid_q <= codeValid_d;
            frameErr_q  <= frameErr_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            keys_q      <= keys_d;
            select_q    <= select_d;
        end
    end

    // Frame FSM; an edge in the same cycle as the timeout wins and keeps the frame alive.
    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        toCnt_d     = toCnt_q;
        scanCode_d  = scanCode_q;
        codeValid_d = 1'b0;
        frameErr_d  = 1'b0;

        if (state_q == IDLE) begin
            toCnt_d = '0;
            if (fall && !dataBit) begin
                state_d  = DATA;
                bitCnt_d = '0;
            end
        end else if (fall) begin
            toCnt_d = '0;
            case (state_q)
                DATA: begin
                    shift_d  = {dataBit, shift_q[7:1]};
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    parity_d = dataBit;
                    state_d  = STOP;
                end
                default: begin
                    state_d = IDLE;
                    if (dataBit && ((^shift_q) ^ parity_q)) begin
                        scanCode_d  = shift_q;
                        codeValid_d = 1'b1;
                    end else begin
                        frameErr_d = 1'b1;
                    end
                end
            endcase
        end else if (toCnt_q == TO_LAST) begin
            state_d    = IDLE;
            toCnt_d    = '0;
            frameErr_d = 1'b1;
        end else begin
            toCnt_d = toCnt_q + CW'(1);
        end
    end

    always_comb begin
        case (scanCode_q)
            8'h75:   arrowOh = 4'b0001;
            8'h72:   arrowOh = 4'b0010;
            8'h6B:   arrowOh = 4'b0100;
            8'h74:   arrowOh = 4'b1000;
            default: arrowOh = 4'b0000;
        endcase
    end

    // Prefix flags accumulate until a non-prefix byte consumes them; errors drop them.
    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        keys_d   = keys_q;
        select_d = select_q;

        if (codeValid_q) begin
            if (scanCode_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (scanCode_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (ext_q && arrowOh != 4'b0000) begin
                    if (!brk_q)
                        keys_d = arrowOh;
                    else if (keys_q == arrowOh)
                        keys_d = 4'b0000;
                end else if (!ext_q && scanCode_q == 8'h5A) begin
                    select_d = ~brk_q;
                end
            end
        end else if (frameErr_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
    end

    assign keys       = keys_q;
    assign select     = select_q;
    assign scan_code  = scanCode_q;
    assign code_valid = codeValid_q;
    assign frame_err  = frameErr_q;

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Self-checking bench for ps2_arrow_decoder: vector table plus scoreboard of
// code_valid / frame_err events, with hand sequences for reset and timeout.
module tb_ps2_arrow_decoder;

    localparam int TO = 100;
    localparam int HALF = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] keys;
    logic       select;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_err;

    ps2_arrow_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .keys(keys),
        .select(select),
        .scan_code(scan_code),
        .code_valid(code_valid),
        .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] code;
        bit         badParity;
        bit         badStop;
        logic [3:0] expKeys;
        logic       expSelect;
    } vec_t;

    typedef struct {
        bit         isErr;
        logic [7:0] code;
    } evt_t;

    vec_t vecs[$];
    evt_t expQ[$];
    logic [7:0] lastGood = 8'h00;
    int checks = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Scoreboard: every code_valid / frame_err pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && (code_valid || frame_err)) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_event", {6'd0, code_valid, frame_err}, 8'h00);
            end else begin
                evt_t e;
                e = expQ.pop_front();
                checkOutput("event_kind", {6'd0, code_valid, frame_err},
                            e.isErr ? 8'h01 : 8'h02);
                if (!e.isErr) lastGood = e.code;
                checkOutput(e.isErr ? "scan_code_held" : "scan_code", scan_code, lastGood);
            end
        end
    end

    task automatic ps2Bit(input logic b);
        @(negedge clock);
        ps2_data = b;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b1;
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        expQ.delete();
        lastGood = 8'h00;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        checkOutput(name, 8'(expQ.size()), 8'd0);
        repeat (4) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic [7:0] code, input bit badParity, input bit badStop);
        evt_t e;
        logic par;
        e.isErr = badParity || badStop;
        e.code = code;
        expQ.push_back(e);
        par = ~(^code);
        if (badParity) par = ~par;
        ps2Bit(1'b0);
        for (int i = 0; i < 8; i++) ps2Bit(code[i]);
        ps2Bit(par);
        ps2Bit(badStop ? 1'b0 : 1'b1);
        @(negedge clock);
        ps2_data = 1'b1;
        waitDrain("event_drain");
    endtask

    task automatic addVec(input logic [7:0] c, input bit bp, input bit bs,
                          input logic [3:0] k, input logic s);
        vec_t v;
        v.code = c; v.badParity = bp; v.badStop = bs; v.expKeys = k; v.expSelect = s;
        vecs.push_back(v);
    endtask

    initial begin
        int cyc;
        bit seen;

        // Reset mid-frame: start bit plus four data bits, then reset.
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        ps2Bit(1'b0);
        for (int i = 0; i < 4; i++) ps2Bit(1'b1);
        doReset();
        checkOutput("partial_scan", scan_code, 8'h00);
        applyStimulus(8'h5A, 0, 0);
        checkOutput("enter_select", {7'd0, select}, 8'h01);

        doReset();
        checkOutput("rst_keys", {4'd0, keys}, 8'h00);
        checkOutput("rst_select", {7'd0, select}, 8'h00);
        checkOutput("rst_scan", scan_code, 8'h00);
        checkOutput("rst_pulses", {6'd0, code_valid, frame_err}, 8'h00);

        addVec(8'hE0, 0, 0, 4'b0000, 0);
        addVec(8'h75, 0, 0, 4'b0001, 0);
        addVec(8'hE0, 0, 0, 4'b0001, 0);
        addVec(8'hF0, 0, 0, 4'b0001, 0);
        addVec(8'h75, 0, 0, 4'b0000, 0);
        addVec(8'hE0, 0, 0, 4'b0000, 0);
        addVec(8'h6B, 0, 0, 4'b0100, 0);
        addVec(8'hE0, 0, 0, 4'b0100, 0);
        addVec(8'h74, 0, 0, 4'b1000, 0);
        addVec(8'hE0, 0, 0, 4'b1000, 0);
        addVec(8'hF0, 0, 0, 4'b1000, 0);
        addVec(8'h6B, 0, 0, 4'b1000, 0);
        addVec(8'hE0, 0, 0, 4'b1000, 0);
        addVec(8'hF0, 0, 0, 4'b1000, 0);
        addVec(8'h74, 0, 0, 4'b0000, 0);
        addVec(8'hE0, 0, 0, 4'b0000, 0);
        addVec(8'h72, 1, 0, 4'b0000, 0);
        addVec(8'h72, 0, 0, 4'b0000, 0);
        addVec(8'h5A, 0, 0, 4'b0000, 1);
        addVec(8'h1C, 0, 0, 4'b0000, 1);
        addVec(8'hE0, 0, 0, 4'b0000, 1);
        addVec(8'h75, 0, 0, 4'b0001, 1);
        addVec(8'hF0, 0, 0, 4'b0001, 1);
        addVec(8'h5A, 0, 0, 4'b0001, 0);
        addVec(8'hE0, 0, 0, 4'b0001, 0);
        addVec(8'h6B, 0, 1, 4'b0001, 0);
        addVec(8'h6B, 0, 0, 4'b0001, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].code, vecs[i].badParity, vecs[i].badStop);
            checkOutput($sformatf("keys_v%0d", i), {4'd0, keys}, {4'd0, vecs[i].expKeys});
            checkOutput($sformatf("select_v%0d", i), {7'd0, select}, {7'd0, vecs[i].expSelect});
        end

        // Timeout: start bit and three data bits, then the PS/2 clock stays high.
        begin
            evt_t e;
            e.isErr = 1'b1;
            e.code = 8'h00;
            expQ.push_back(e);
        end
        ps2Bit(1'b0);
        ps2Bit(1'b1);
        ps2Bit(1'b0);
        @(negedge clock);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        cyc = 0;
        seen = 0;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b1;
        cyc = HALF;
        while (!seen && cyc < 3 * TO) begin
            if (frame_err) seen = 1;
            else begin
                @(negedge clock);
                cyc++;
            end
        end
        checkOutput("timeout_seen", {7'd0, seen}, 8'h01);
        checkOutput("timeout_early", {7'd0, (cyc >= TO - 2)}, 8'h01);
        checkOutput("timeout_late", {7'd0, (cyc <= TO + 8)}, 8'h01);
        waitDrain("timeout_drain");
        checkOutput("timeout_keys", {4'd0, keys}, 8'h01);
        checkOutput("timeout_select", {7'd0, select}, 8'h00);
        applyStimulus(8'hE0, 0, 0);
        applyStimulus(8'h74, 0, 0);
        checkOutput("post_timeout_keys", {4'd0, keys}, 8'h08);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
